// File: rtl/adc_scan_ctrl_if.sv
// Bus bundle between the ADC0808 scan controller, the converter pins and the sample consumer.
interface adc_scan_ctrl_if #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned DATA_W = 8
);
  logic              enable;
  logic [NUM_CH-1:0] ch_mask;
  logic              eoc;
  logic [DATA_W-1:0] data_in;
  logic              ale;
  logic              start;
  logic              oe;
  logic [2:0]        addr;
  logic              busy;
  logic              sample_valid;
  logic [2:0]        sample_ch;
  logic [DATA_W-1:0] sample_data;
  logic              timeout_err;

  modport master (
    input  enable, ch_mask, eoc, data_in,
    output ale, start, oe, addr, busy, sample_valid, sample_ch, sample_data, timeout_err
  );

  modport slave (
    output enable, ch_mask, eoc, data_in,
    input  ale, start, oe, addr, busy, sample_valid, sample_ch, sample_data, timeout_err
  );
endinterface

// File: rtl/adc_scan_ctrl.sv
// Round-robin multi-channel ADC0808 scan controller: ALE/START/OE sequencing,
// EOC synchronisation, per-conversion timeout and tagged one-cycle result strobe.
module adc_scan_ctrl #(
  parameter int unsigned NUM_CH       = 8,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned ALE_CYCLES   = 2,
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned OE_CYCLES    = 2,
  parameter int unsigned EOC_TIMEOUT  = 1024
) (
  input  logic           clk,
  input  logic           reset,
  adc_scan_ctrl_if.master bus
);

  localparam int unsigned AW       = 3;
  localparam int unsigned MAX_P1   = (ALE_CYCLES > START_CYCLES) ? ALE_CYCLES : START_CYCLES;
  localparam int unsigned MAX_P2   = (MAX_P1 > OE_CYCLES) ? MAX_P1 : OE_CYCLES;
  localparam int unsigned MAX_CNT  = (MAX_P2 > EOC_TIMEOUT) ? MAX_P2 : EOC_TIMEOUT;
  localparam int unsigned CNT_W    = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] ALE_LAST   = CNT_W'(ALE_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] OE_LAST    = CNT_W'(OE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(EOC_TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_START, S_WAIT_LO, S_WAIT_HI, S_READ, S_NEXT
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              ale_q, ale_d;
  logic              start_q, start_d;
  logic              oe_q, oe_d;
  logic              busy_q, busy_d;
  logic              sample_valid_q, sample_valid_d;
  logic              timeout_err_q, timeout_err_d;
  logic [AW-1:0]     sample_ch_q, sample_ch_d;
  logic [DATA_W-1:0] sample_data_q, sample_data_d;
  logic              eoc_meta_q, eoc_meta_d;
  logic              eoc_s_q, eoc_s_d;

  logic [7:0]        mask8;
  logic [AW:0]       pick_sum;
  logic [AW-1:0]     pick;
  logic              scan_go;

  assign mask8   = 8'(bus.ch_mask);
  assign scan_go = bus.enable && (bus.ch_mask != '0);

  // Next channel: first set mask bit strictly above the pointer, wrapping modulo NUM_CH.
  always_comb begin
    pick_sum = '0;
    pick     = ptr_q;
    for (int i = NUM_CH; i >= 1; i--) begin
      pick_sum = 4'(ptr_q) + 4'(i);
      if (pick_sum >= 4'(NUM_CH)) pick_sum = pick_sum - 4'(NUM_CH);
      if (mask8[pick_sum[AW-1:0]]) pick = pick_sum[AW-1:0];
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    ptr_d          = ptr_q;
    addr_d         = addr_q;
    sample_ch_d    = sample_ch_q;
    sample_data_d  = sample_data_q;
    sample_valid_d = 1'b0;
    timeout_err_d  = 1'b0;
    eoc_meta_d     = bus.eoc;
    eoc_s_d        = eoc_meta_q;

    case (state_q)
      S_IDLE, S_NEXT: begin
        if (scan_go) begin
          state_d = S_SELECT;
          cnt_d   = '0;
          ptr_d   = pick;
          addr_d  = pick;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SELECT: begin
        if (cnt_q == ALE_LAST) begin
          state_d = S_START;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_START: begin
        if (cnt_q == START_LAST) begin
          state_d = S_WAIT_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // Timeout spans both wait states; only a seen EOC rise escapes it.
      S_WAIT_LO, S_WAIT_HI: begin
        if ((state_q == S_WAIT_HI) && eoc_s_q) begin
          state_d = S_READ;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d       = S_NEXT;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if ((state_q == S_WAIT_LO) && !eoc_s_q) state_d = S_WAIT_HI;
        end
      end
      S_READ: begin
        if (cnt_q == OE_LAST) begin
          state_d        = S_NEXT;
          sample_data_d  = bus.data_in;
          sample_ch_d    = addr_q;
          sample_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    ale_d   = (state_d == S_SELECT);
    start_d = (state_d == S_START);
    oe_d    = (state_d == S_READ);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      ptr_q          <= AW'(NUM_CH - 1);
      addr_q         <= '0;
      ale_q          <= 1'b0;
      start_q        <= 1'b0;
      oe_q           <= 1'b0;
      busy_q         <= 1'b0;
      sample_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      sample_ch_q    <= '0;
      sample_data_q  <= '0;
      eoc_meta_q     <= 1'b0;
      eoc_s_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ptr_q          <= ptr_d;
      addr_q         <= addr_d;
      ale_q          <= ale_d;
      start_q        <= start_d;
      oe_q           <= oe_d;
      busy_q         <= busy_d;
      sample_valid_q <= sample_valid_d;
      timeout_err_q  <= timeout_err_d;
      sample_ch_q    <= sample_ch_d;
      sample_data_q  <= sample_data_d;
      eoc_meta_q     <= eoc_meta_d;
      eoc_s_q        <= eoc_s_d;
    end
  end

  assign bus.ale          = ale_q;
  assign bus.start        = start_q;
  assign bus.oe           = oe_q;
  assign bus.addr         = addr_q;
  assign bus.busy         = busy_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.timeout_err  = timeout_err_q;
  assign bus.sample_ch    = sample_ch_q;
  assign bus.sample_data  = sample_data_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Bench for adc_scan_ctrl: behavioural ADC0808 model, scan-order reference and scenario tasks.
module tb_adc_scan_ctrl;
  localparam int NCH = 8;
  localparam int TO  = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  adc_scan_ctrl_if #(.NUM_CH(NCH), .DATA_W(8)) bus ();

  adc_scan_ctrl #(
    .NUM_CH(NCH), .DATA_W(8), .ALE_CYCLES(2), .START_CYCLES(2),
    .OE_CYCLES(2), .EOC_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct { int ch; int data; int cyc; } samp_t;

  samp_t      samp_q[$];
  int         to_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  int         viol     = 0;
  logic [7:0] adc_val [8];
  int         lo_delay, hi_delay, lo_cnt, hi_cnt;
  bit         rand_delays, eoc_stuck;
  logic       start_prev, sv_prev, te_prev;
  logic [2:0] adc_ch;

  // Reference scan order: next enabled channel above p, else the lowest enabled one.
  function automatic int ref_next(input int p, input logic [7:0] m);
    int chans[$];
    for (int i = 0; i < NCH; i++) if (m[3'(i)]) chans.push_back(i);
    if (chans.size() == 0) return -1;
    foreach (chans[j]) if (chans[j] > p) return chans[j];
    return chans[0];
  endfunction

  function automatic int s_ch(input int i);
    return (i < samp_q.size()) ? samp_q[i].ch : -1;
  endfunction

  function automatic int s_data(input int i);
    return (i < samp_q.size()) ? samp_q[i].data : -1;
  endfunction

  // One clock: advance the ADC model, record strobes and protocol violations.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.ale) adc_ch = bus.addr;
    if (bus.start && !start_prev) begin
      if (rand_delays) begin
        lo_delay = int'($urandom_range(6, 1));
        hi_delay = int'($urandom_range(30, 4));
      end
      lo_cnt = lo_delay;
      hi_cnt = 0;
    end else if (lo_cnt > 0) begin
      lo_cnt--;
      if (lo_cnt == 0) begin
        bus.eoc = 1'b0;
        hi_cnt  = hi_delay;
      end
    end else if (hi_cnt > 0) begin
      hi_cnt--;
      if (hi_cnt == 0 && !eoc_stuck) bus.eoc = 1'b1;
    end
    start_prev  = bus.start;
    bus.data_in = adc_val[adc_ch];
    if (bus.sample_valid)
      samp_q.push_back('{ch: int'(bus.sample_ch), data: int'(bus.sample_data), cyc: cyc});
    if (bus.timeout_err) to_q.push_back(cyc);
    if (int'(bus.ale) + int'(bus.start) + int'(bus.oe) > 1) viol++;
    if (bus.sample_valid && bus.timeout_err) viol++;
    if ((bus.sample_valid && sv_prev) || (bus.timeout_err && te_prev)) viol++;
    sv_prev = bus.sample_valid;
    te_prev = bus.timeout_err;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.ch_mask = '0;
    bus.eoc = 1'b1;
    eoc_stuck = 1'b0;
    lo_cnt = 0;
    hi_cnt = 0;
    start_prev = 1'b0;
    adc_ch = '0;
    step();
    step();
    reset = 1'b0;
    samp_q.delete();
    to_q.delete();
  endtask

  task automatic wait_samples(input int n, input int budget);
    for (int c = 0; c < budget && samp_q.size() < n; c++) step();
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    bus.enable = 1'b1;
    bus.ch_mask = 8'hFF;
    step();
    step();
    n_checks++;
    if ({bus.ale, bus.start, bus.oe, bus.busy, bus.sample_valid, bus.timeout_err} !== 6'b0)
      $display("FAIL reset_ctrl: got %b expected 000000",
               {bus.ale, bus.start, bus.oe, bus.busy, bus.sample_valid, bus.timeout_err});
    else n_pass++;
    n_checks++;
    if ({bus.addr, bus.sample_ch} !== 6'b0)
      $display("FAIL reset_addr: got %b expected 000000", {bus.addr, bus.sample_ch});
    else n_pass++;
    n_checks++;
    if (bus.sample_data !== 8'h00)
      $display("FAIL reset_data: got %h expected 00", bus.sample_data);
    else n_pass++;
    bus.enable = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_single();
    int aw, sw, ow, bad;
    do_reset();
    adc_val[2] = 8'hA5;
    rand_delays = 1'b0;
    lo_delay = 3;
    hi_delay = 20;
    bus.ch_mask = 8'h04;
    bus.enable = 1'b1;
    step();
    n_checks++;
    if (bus.ale !== 1'b1 || bus.addr !== 3'd2)
      $display("FAIL single_first_ale: got ale=%b addr=%0d expected ale=1 addr=2", bus.ale, bus.addr);
    else n_pass++;
    aw = int'(bus.ale);
    sw = 0;
    ow = 0;
    bad = 0;
    for (int c = 0; c < 300 && samp_q.size() < 2; c++) begin
      step();
      if (samp_q.size() == 0) begin
        aw += int'(bus.ale);
        sw += int'(bus.start);
        ow += int'(bus.oe);
      end
      if (bus.busy && bus.addr !== 3'd2) bad++;
    end
    n_checks++;
    if (aw != 2 || sw != 2 || ow != 2)
      $display("FAIL single_widths: got ale=%0d start=%0d oe=%0d expected 2 2 2", aw, sw, ow);
    else n_pass++;
    n_checks++;
    if (bad != 0) $display("FAIL single_addr_stable: got %0d bad cycles expected 0", bad);
    else n_pass++;
    n_checks++;
    if (s_ch(0) != 2 || s_data(0) != 'hA5)
      $display("FAIL single_sample: got ch=%0d data=%0h expected ch=2 data=a5", s_ch(0), s_data(0));
    else n_pass++;
    n_checks++;
    if (s_ch(1) != 2) $display("FAIL single_repeat: got ch=%0d expected 2", s_ch(1));
    else n_pass++;
  endtask

  task automatic scan_check(input string name, input logic [7:0] mask, input int n);
    int p;
    do_reset();
    rand_delays = 1'b1;
    bus.ch_mask = mask;
    bus.enable = 1'b1;
    wait_samples(n, 80 * n);
    p = NCH - 1;
    for (int i = 0; i < n; i++) begin
      p = ref_next(p, mask);
      n_checks++;
      if (s_ch(i) != p || s_data(i) != int'(adc_val[3'(p)]))
        $display("FAIL %s[%0d]: got ch=%0d data=%0h expected ch=%0d data=%0h",
                 name, i, s_ch(i), s_data(i), p, adc_val[3'(p)]);
      else n_pass++;
    end
  endtask

  task automatic test_scan_order();
    for (int i = 0; i < NCH; i++) adc_val[i] = 8'(i * 16);
    scan_check("scan_order", 8'b1010_0101, 6);
  endtask

  task automatic test_random_masks();
    logic [7:0] m;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < NCH; i++) adc_val[i] = 8'($urandom);
      m = 8'($urandom_range(255, 1));
      scan_check("rand_mask", m, 5);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    logic prev_sv;
    do_reset();
    rand_delays = 1'b1;
    bus.ch_mask = 8'h03;
    bus.enable = 1'b1;
    bad = 0;
    prev_sv = 1'b0;
    for (int c = 0; c < 400 && samp_q.size() < 4; c++) begin
      step();
      if (prev_sv && (bus.ale !== 1'b1)) bad++;
      prev_sv = bus.sample_valid;
    end
    step();
    if (prev_sv && (bus.ale !== 1'b1)) bad++;
    n_checks++;
    if (bad != 0 || samp_q.size() < 4)
      $display("FAIL back_to_back: got %0d gaps, %0d samples expected 0 gaps, 4 samples",
               bad, samp_q.size());
    else n_pass++;
  endtask

  task automatic test_timeout();
    int we;
    logic prev_start;
    do_reset();
    adc_val[1] = 8'h3C;
    adc_val[3] = 8'hC3;
    rand_delays = 1'b0;
    lo_delay = 3;
    hi_delay = 10;
    bus.ch_mask = 8'h0A;
    bus.enable = 1'b1;
    wait_samples(1, 200);
    eoc_stuck = 1'b1;
    we = -1000;
    prev_start = 1'b0;
    for (int c = 0; c < 300 && to_q.size() == 0; c++) begin
      step();
      if (prev_start && !bus.start) we = cyc;
      prev_start = bus.start;
    end
    n_checks++;
    if (to_q.size() != 1 || (to_q.size() == 1 && to_q[0] - we != TO - 1))
      $display("FAIL timeout_delay: got %0d pulses, delay %0d expected 1 pulse, delay %0d",
               to_q.size(), (to_q.size() > 0) ? to_q[0] - we : -1, TO - 1);
    else n_pass++;
    n_checks++;
    if (samp_q.size() != 1 || bus.sample_data !== 8'h3C || bus.sample_ch !== 3'd1)
      $display("FAIL timeout_no_sample: got n=%0d ch=%0d data=%h expected n=1 ch=1 data=3c",
               samp_q.size(), bus.sample_ch, bus.sample_data);
    else n_pass++;
    step();
    n_checks++;
    if (bus.ale !== 1'b1 || bus.addr !== 3'd1)
      $display("FAIL timeout_next_ch: got ale=%b addr=%0d expected ale=1 addr=1", bus.ale, bus.addr);
    else n_pass++;
    eoc_stuck = 1'b0;
    wait_samples(2, 200);
    n_checks++;
    if (s_ch(1) != 1 || s_data(1) != 'h3C)
      $display("FAIL timeout_recover: got ch=%0d data=%0h expected ch=1 data=3c", s_ch(1), s_data(1));
    else n_pass++;
  endtask

  task automatic test_enable_drop();
    int ale_seen;
    do_reset();
    adc_val[3] = 8'h7E;
    rand_delays = 1'b0;
    lo_delay = 3;
    hi_delay = 20;
    bus.ch_mask = 8'h08;
    bus.enable = 1'b1;
    for (int c = 0; c < 100 && hi_cnt != 15; c++) step();
    bus.enable = 1'b0;
    wait_samples(1, 200);
    n_checks++;
    if (s_ch(0) != 3 || s_data(0) != 'h7E)
      $display("FAIL en_drop_sample: got ch=%0d data=%0h expected ch=3 data=7e", s_ch(0), s_data(0));
    else n_pass++;
    step();
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL en_drop_idle: got busy=%b expected 0", bus.busy);
    else n_pass++;
    ale_seen = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      ale_seen += int'(bus.ale) + int'(bus.busy);
    end
    n_checks++;
    if (ale_seen != 0 || samp_q.size() != 1)
      $display("FAIL en_drop_quiet: got activity=%0d samples=%0d expected 0 and 1",
               ale_seen, samp_q.size());
    else n_pass++;
  endtask

  task automatic test_mask_zero();
    int act;
    do_reset();
    bus.ch_mask = 8'h00;
    bus.enable = 1'b1;
    act = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      act += int'(bus.busy) + int'(bus.ale) + int'(bus.start) + int'(bus.oe)
           + int'(bus.sample_valid) + int'(bus.timeout_err);
    end
    n_checks++;
    if (act != 0) $display("FAIL mask_zero_idle: got %0d active cycles expected 0", act);
    else n_pass++;
    bus.ch_mask = 8'h80;
    step();
    n_checks++;
    if (bus.ale !== 1'b1 || bus.addr !== 3'd7 || bus.busy !== 1'b1)
      $display("FAIL mask_zero_start: got ale=%b addr=%0d busy=%b expected 1 7 1",
               bus.ale, bus.addr, bus.busy);
    else n_pass++;
  endtask

  task automatic test_reset_in_read();
    int seen;
    do_reset();
    adc_val[4] = 8'h44;
    adc_val[0] = 8'h11;
    rand_delays = 1'b0;
    lo_delay = 3;
    hi_delay = 10;
    bus.ch_mask = 8'h10;
    bus.enable = 1'b1;
    seen = 0;
    for (int c = 0; c < 200 && seen == 0; c++) begin
      step();
      if (bus.oe) seen = 1;
    end
    reset = 1'b1;
    step();
    n_checks++;
    if (seen != 1 || bus.oe !== 1'b0 || bus.busy !== 1'b0 || bus.sample_valid !== 1'b0)
      $display("FAIL reset_read: got seen=%0d oe=%b busy=%b valid=%b expected 1 0 0 0",
               seen, bus.oe, bus.busy, bus.sample_valid);
    else n_pass++;
    n_checks++;
    if (samp_q.size() != 0 || bus.sample_data !== 8'h00)
      $display("FAIL reset_read_discard: got n=%0d data=%h expected n=0 data=00",
               samp_q.size(), bus.sample_data);
    else n_pass++;
    reset = 1'b0;
    bus.ch_mask = 8'h01;
    wait_samples(1, 200);
    n_checks++;
    if (s_ch(0) != 0 || s_data(0) != 'h11)
      $display("FAIL reset_read_restart: got ch=%0d data=%0h expected ch=0 data=11", s_ch(0), s_data(0));
    else n_pass++;
  endtask

  task automatic test_protocol();
    n_checks++;
    if (viol != 0) $display("FAIL protocol: got %0d violations expected 0", viol);
    else n_pass++;
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.ch_mask = '0;
    bus.eoc = 1'b1;
    bus.data_in = '0;
    sv_prev = 1'b0;
    te_prev = 1'b0;
    rand_delays = 1'b0;
    lo_delay = 3;
    hi_delay = 20;
    for (int i = 0; i < NCH; i++) adc_val[i] = '0;
    test_reset();
    test_single();
    test_scan_order();
    test_random_masks();
    test_back_to_back();
    test_timeout();
    test_enable_drop();
    test_mask_zero();
    test_reset_in_read();
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
